// File: rtl/alarm_pkg.sv
// Shared constants for the alarm sequencer: state encoding, time field
// widths and the time-compare helper.
package alarm_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RING   = 2'd1;
    localparam logic [1:0] ST_SNOOZE = 2'd2;

    // True when the running time equals the stored alarm time.
    function automatic logic time_eq(
        input logic [HOUR_W-1:0] a_h,
        input logic [MIN_W-1:0]  a_m,
        input logic [SEC_W-1:0]  a_s,
        input logic [HOUR_W-1:0] b_h,
        input logic [MIN_W-1:0]  b_m,
        input logic [SEC_W-1:0]  b_s
    );
        return (a_h == b_h) && (a_m == b_m) && (a_s == b_s);
    endfunction

endpackage

// File: rtl/alarm_sequencer_rise_edge.sv
// Registers a level and produces a one-cycle pulse on its rising edge.
// The pulse is combinational from the live level so the consumer reacts
// on the very edge where the level is first sampled high.
module rise_edge (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic rise_o
);

    logic level_q;

    // Previous-cycle copy of the level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= d_i;
        end
    end

    assign rise_o = d_i & ~level_q;

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm sequencing: starts ringing on a rising time match, supports a
// bounded number of snoozes, auto-times-out and can be stopped or disarmed.
module alarm_sequencer
    import alarm_pkg::*;
#(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sec_tick,
    input  logic              alarm_en,
    input  logic [HOUR_W-1:0] cur_h,
    input  logic [MIN_W-1:0]  cur_m,
    input  logic [SEC_W-1:0]  cur_s,
    input  logic [HOUR_W-1:0] alm_h,
    input  logic [MIN_W-1:0]  alm_m,
    input  logic [SEC_W-1:0]  alm_s,
    input  logic              snooze_pb,
    input  logic              stop_pb,
    output logic              ring,
    output logic              blink,
    output logic [1:0]        state_o,
    output logic [1:0]        snooze_cnt_o
);

    localparam logic [7:0] RING_LAST = 8'(RING_SECS - 1);
    localparam logic [9:0] SNZ_LAST  = 10'(SNOOZE_SECS - 1);
    localparam logic [1:0] SNZ_MAX   = 2'(MAX_SNOOZE);

    logic       match_c;
    logic       match_rise_s;
    logic       snooze_rise_s;
    logic       stop_rise_s;

    logic [1:0] state_q,      state_d;
    logic [7:0] ring_cnt_q,   ring_cnt_d;
    logic [9:0] snz_cnt_q,    snz_cnt_d;
    logic [1:0] snooze_cnt_q, snooze_cnt_d;
    logic       blink_q,      blink_d;
    logic       blink_nxt_s;
    logic       ring_q,       ring_d;

    assign match_c = time_eq(cur_h, cur_m, cur_s, alm_h, alm_m, alm_s);

    rise_edge u_match_edge (
        .clk    (clk),
        .reset  (reset),
        .d_i    (match_c),
        .rise_o (match_rise_s)
    );

    rise_edge u_snooze_edge (
        .clk    (clk),
        .reset  (reset),
        .d_i    (snooze_pb),
        .rise_o (snooze_rise_s)
    );

    rise_edge u_stop_edge (
        .clk    (clk),
        .reset  (reset),
        .d_i    (stop_pb),
        .rise_o (stop_rise_s)
    );

    // Next-state and counter logic; button events pre-empt the second tick.
    always_comb begin
        state_d      = state_q;
        ring_cnt_d   = ring_cnt_q;
        snz_cnt_d    = snz_cnt_q;
        snooze_cnt_d = snooze_cnt_q;
        blink_nxt_s  = blink_q;
        case (state_q)
            ST_IDLE: begin
                if (match_rise_s && alarm_en) begin
                    state_d      = ST_RING;
                    ring_cnt_d   = 8'd0;
                    snooze_cnt_d = 2'd0;
                    blink_nxt_s  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RING: begin
                if (!alarm_en || stop_rise_s) begin
                    state_d = ST_IDLE;
                end else if (snooze_rise_s && (snooze_cnt_q < SNZ_MAX)) begin
                    state_d      = ST_SNOOZE;
                    snz_cnt_d    = 10'd0;
                    snooze_cnt_d = snooze_cnt_q + 2'd1;
                end else if (sec_tick) begin
                    if (ring_cnt_q == RING_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        ring_cnt_d  = ring_cnt_q + 8'd1;
                        blink_nxt_s = ~blink_q;
                    end
                end else begin
                    state_d = ST_RING;
                end
            end
            ST_SNOOZE: begin
                if (!alarm_en || stop_rise_s) begin
                    state_d = ST_IDLE;
                end else if (sec_tick) begin
                    if (snz_cnt_q == SNZ_LAST) begin
                        state_d     = ST_RING;
                        ring_cnt_d  = 8'd0;
                        blink_nxt_s = 1'b1;
                    end else begin
                        snz_cnt_d = snz_cnt_q + 10'd1;
                    end
                end else begin
                    state_d = ST_SNOOZE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ring_d  = (state_d == ST_RING);
        blink_d = (state_d == ST_RING) ? blink_nxt_s : 1'b0;
    end

    // State, counters and registered output drives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ring_cnt_q   <= 8'd0;
            snz_cnt_q    <= 10'd0;
            snooze_cnt_q <= 2'd0;
            blink_q      <= 1'b0;
            ring_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ring_cnt_q   <= ring_cnt_d;
            snz_cnt_q    <= snz_cnt_d;
            snooze_cnt_q <= snooze_cnt_d;
            blink_q      <= blink_d;
            ring_q       <= ring_d;
        end
    end

    assign ring         = ring_q;
    assign blink        = blink_q;
    assign state_o      = state_q;
    assign snooze_cnt_o = snooze_cnt_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer with a scoreboard of expected outputs.
module tb_alarm_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       sec_tick;
    logic       alarm_en;
    logic [4:0] cur_h;
    logic [5:0] cur_m;
    logic [5:0] cur_s;
    logic [4:0] alm_h;
    logic [5:0] alm_m;
    logic [5:0] alm_s;
    logic       snooze_pb;
    logic       stop_pb;
    logic       ring;
    logic       blink;
    logic [1:0] state_o;
    logic [1:0] snooze_cnt_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      tag;
        logic       ring;
        logic       blink;
        logic [1:0] st;
        logic [1:0] sc;
    } exp_t;

    exp_t sb_q[$];

    alarm_sequencer #(
        .RING_SECS   (4),
        .SNOOZE_SECS (3),
        .MAX_SNOOZE  (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sec_tick     (sec_tick),
        .alarm_en     (alarm_en),
        .cur_h        (cur_h),
        .cur_m        (cur_m),
        .cur_s        (cur_s),
        .alm_h        (alm_h),
        .alm_m        (alm_m),
        .alm_s        (alm_s),
        .snooze_pb    (snooze_pb),
        .stop_pb      (stop_pb),
        .ring         (ring),
        .blink        (blink),
        .state_o      (state_o),
        .snooze_cnt_o (snooze_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic second();
        repeat (9) cyc();
        sec_tick = 1'b1;
        cyc();
        sec_tick = 1'b0;
    endtask

    task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        cur_h = h;
        cur_m = m;
        cur_s = s;
    endtask

    task automatic push(input string tag, input logic r, input logic b,
                        input logic [1:0] st, input logic [1:0] sc);
        exp_t e;
        e.tag   = tag;
        e.ring  = r;
        e.blink = b;
        e.st    = st;
        e.sc    = sc;
        sb_q.push_back(e);
    endtask

    task automatic cmp(input string tag, input string fld,
                       input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
        end
    endtask

    task automatic check();
        exp_t e;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL sb_empty observed=0 expected=1");
        end else begin
            e = sb_q.pop_front();
            cmp(e.tag, "ring",  {1'b0, ring},  {1'b0, e.ring});
            cmp(e.tag, "blink", {1'b0, blink}, {1'b0, e.blink});
            cmp(e.tag, "state", state_o,       e.st);
            cmp(e.tag, "scnt",  snooze_cnt_o,  e.sc);
        end
    endtask

    // Drive one cycle with the current inputs, then compare.
    task automatic step(input string tag, input logic r, input logic b,
                        input logic [1:0] st, input logic [1:0] sc);
        push(tag, r, b, st, sc);
        cyc();
        check();
    endtask

    // Walk the time onto the alarm so a fresh rising match is produced.
    task automatic approach(input string tag, input logic r, input logic b,
                            input logic [1:0] st, input logic [1:0] sc);
        set_time(5'd7, 6'd29, 6'd59);
        cyc();
        set_time(5'd7, 6'd30, 6'd0);
        step(tag, r, b, st, sc);
    endtask

    initial begin
        reset     = 1'b1;
        sec_tick  = 1'b0;
        alarm_en  = 1'b0;
        snooze_pb = 1'b0;
        stop_pb   = 1'b0;
        set_time(5'd0, 6'd0, 6'd0);
        alm_h = 5'd7;
        alm_m = 6'd30;
        alm_s = 6'd0;

        // Reset state.
        repeat (2) cyc();
        push("reset", 1'b0, 1'b0, 2'd0, 2'd0);
        check();
        reset = 1'b0;
        step("post_reset", 1'b0, 1'b0, 2'd0, 2'd0);

        // Basic ring and timeout after exactly 4 ticks, blink toggling.
        alarm_en = 1'b1;
        approach("ring_start", 1'b1, 1'b1, 2'd1, 2'd0);
        set_time(5'd7, 6'd30, 6'd1);
        push("tick1", 1'b1, 1'b0, 2'd1, 2'd0); second(); check();
        push("tick2", 1'b1, 1'b1, 2'd1, 2'd0); second(); check();
        push("tick3", 1'b1, 1'b0, 2'd1, 2'd0); second(); check();
        push("timeout", 1'b0, 1'b0, 2'd0, 2'd0); second(); check();

        // Snooze then re-ring after 3 ticks.
        approach("ring2", 1'b1, 1'b1, 2'd1, 2'd0);
        set_time(5'd7, 6'd30, 6'd1);
        snooze_pb = 1'b1;
        step("snooze1", 1'b0, 1'b0, 2'd2, 2'd1);
        snooze_pb = 1'b0;
        second();
        push("snz_tick2", 1'b0, 1'b0, 2'd2, 2'd1); second(); check();
        push("snz_end1", 1'b1, 1'b1, 2'd1, 2'd1); second(); check();

        // Second snooze, then a third press is ignored; stop ends it.
        snooze_pb = 1'b1;
        step("snooze2", 1'b0, 1'b0, 2'd2, 2'd2);
        snooze_pb = 1'b0;
        repeat (2) second();
        push("snz_end2", 1'b1, 1'b1, 2'd1, 2'd2); second(); check();
        snooze_pb = 1'b1;
        step("snooze3_ign", 1'b1, 1'b1, 2'd1, 2'd2);
        snooze_pb = 1'b0;
        cyc();
        stop_pb = 1'b1;
        step("stop", 1'b0, 1'b0, 2'd0, 2'd2);
        stop_pb = 1'b0;
        cyc();

        // Count held in IDLE, cleared at next event; stop beats snooze.
        set_time(5'd7, 6'd29, 6'd59);
        step("idle_hold", 1'b0, 1'b0, 2'd0, 2'd2);
        set_time(5'd7, 6'd30, 6'd0);
        step("ring3", 1'b1, 1'b1, 2'd1, 2'd0);
        stop_pb   = 1'b1;
        snooze_pb = 1'b1;
        step("stop_vs_snz", 1'b0, 1'b0, 2'd0, 2'd0);
        stop_pb   = 1'b0;
        snooze_pb = 1'b0;
        push("no_rering", 1'b0, 1'b0, 2'd0, 2'd0);
        repeat (2) second();
        check();

        // Disarmed at the match: no ring, not even when re-armed on a held match.
        alarm_en = 1'b0;
        approach("disarmed", 1'b0, 1'b0, 2'd0, 2'd0);
        alarm_en = 1'b1;
        step("rearm_held", 1'b0, 1'b0, 2'd0, 2'd0);

        // Disarm during SNOOZE.
        approach("ring4", 1'b1, 1'b1, 2'd1, 2'd0);
        snooze_pb = 1'b1;
        step("snooze4", 1'b0, 1'b0, 2'd2, 2'd1);
        snooze_pb = 1'b0;
        alarm_en  = 1'b0;
        step("disarm_snz", 1'b0, 1'b0, 2'd0, 2'd1);
        push("no_late_ring", 1'b0, 1'b0, 2'd0, 2'd1);
        repeat (4) second();
        check();
        alarm_en = 1'b1;

        // Reset mid-ring with a tick and a button edge in the same cycle.
        approach("ring5", 1'b1, 1'b1, 2'd1, 2'd0);
        set_time(5'd7, 6'd29, 6'd59);
        push("ring5_t1", 1'b1, 1'b0, 2'd1, 2'd0); second(); check();
        sec_tick = 1'b1;
        stop_pb  = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        push("async_rst", 1'b0, 1'b0, 2'd0, 2'd0);
        check();
        sec_tick = 1'b0;
        stop_pb  = 1'b0;
        step("rst_held", 1'b0, 1'b0, 2'd0, 2'd0);
        reset = 1'b0;
        step("rst_rel", 1'b0, 1'b0, 2'd0, 2'd0);
        approach("ring_after_rst", 1'b1, 1'b1, 2'd1, 2'd0);

        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alarm_sequencer.md
# alarm_sequencer

Alarm control state machine for the digital clock. It compares the running time against the stored alarm time and decides when the alarm rings, snoozes, times out or is dismissed. It sits between the time counter / alarm-setting logic and the LED/buzzer output, replacing a bare "time equals alarm" comparison with sequenced ringing behaviour. All timing is driven by the clock's existing one-second tick.

## Interface
Parameters:
- RING_SECS, 60: seconds the alarm rings before auto-timeout (2..255)
- SNOOZE_SECS, 300: snooze length in seconds (2..1023)
- MAX_SNOOZE, 3: snoozes allowed per alarm event (0..3)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- sec_tick  in  1  one-cycle pulse, once per second
- alarm_en  in  1  alarm armed (level, from switch)
- cur_h / cur_m / cur_s  in  5/6/6  current time
- alm_h / alm_m / alm_s  in  5/6/6  alarm time
- snooze_pb  in  1  snooze button, debounced level
- stop_pb  in  1  stop button, debounced level
- ring  out  1  high while in RINGING
- blink  out  1  1 Hz flashing LED drive while ringing
- state_o  out  2  current state: 0 IDLE, 1 RINGING, 2 SNOOZE
- snooze_cnt_o  out  2  snoozes used in current event

## Operation
- match_c = (cur_h==alm_h && cur_m==alm_m && cur_s==alm_s), combinational. match_q is match_c registered. match_rise = match_c & ~match_q.
- Button edges: snooze_rise = snooze_pb & ~snooze_q, stop_rise = stop_pb & ~stop_q, where snooze_q and stop_q are the registered levels.
- IDLE: on match_rise & alarm_en, go to RINGING; ring_cnt=0, snooze_cnt=0, blink=1.
- RINGING transitions, in priority order:
  - ~alarm_en goes to IDLE.
  - stop_rise goes to IDLE.
  - snooze_rise with snooze_cnt<MAX_SNOOZE goes to SNOOZE; snz_cnt=0, snooze_cnt+1.
  - When sec_tick and ring_cnt==RING_SECS-1, go to IDLE (timeout).
  - Otherwise, on sec_tick: ring_cnt+1 and blink toggles.
  - snooze_rise with snooze_cnt==MAX_SNOOZE is ignored; the alarm keeps ringing.
- SNOOZE transitions, in priority order:
  - ~alarm_en goes to IDLE.
  - stop_rise goes to IDLE.
  - When sec_tick and snz_cnt==SNOOZE_SECS-1, go to RINGING; ring_cnt=0, blink=1.
  - Otherwise, on sec_tick: snz_cnt+1.
  - snooze_rise is ignored.
- match_rise in RINGING/SNOOZE is ignored. There is no re-trigger until the state is back in IDLE and a new rising match occurs.
- If compare stays true after a stop, there is no re-ring (edge-based).
- ring = (state==RINGING). blink is forced to 0 outside RINGING.
- snooze_cnt_o holds its value in IDLE until the next event start.
- Counters never wrap. Each is bounded by its terminal compare. Widths: ring_cnt 8 bits, snz_cnt 10 bits, snooze_cnt 2 bits.

## Timing
- Reset values: state=IDLE, ring=0, blink=0, state_o=0, snooze_cnt_o=0; all counters 0; match_q, snooze_q, stop_q = 0.
- All outputs are registered.
- Latency:
  - ring rises at the first clock edge at which match_c=1 and alarm_en=1.
  - ring falls at the edge where stop_rise or ~alarm_en is sampled.
- Same-cycle sec_tick and button edge: the button takes priority and the tick is dropped.
- Same-cycle stop_rise and snooze_rise: stop wins.
- Timeout: ring lasts exactly RING_SECS ticks, counting from the first tick after entry.
- Snooze: lasts exactly SNOOZE_SECS ticks.
- Reset mid-ring or mid-snooze returns immediately (asynchronously) to IDLE with ring=0.

## Structure
- Package alarm_pkg:
  - state encoding constants ST_IDLE=0, ST_RING=1, ST_SNOOZE=2;
  - widths HOUR_W=5, MIN_W=6, SEC_W=6.
- One sub-module, rise_edge: registered level plus rising-edge pulse, asynchronous reset. It is instantiated three times, for match, snooze_pb and stop_pb.
- The state machine and counters live in alarm_sequencer.

## Test plan
Bench parameters: RING_SECS=4, SNOOZE_SECS=3, MAX_SNOOZE=2; sec_tick every 10 clocks.
- Alarm 07:30:00, alarm_en=1, time steps 07:29:59 to 07:30:00 -> ring=1 one edge later; after 4 ticks, ring=0 and state_o=0.
- Ringing, pulse snooze_pb -> state_o=2, snooze_cnt_o=1, ring=0; after 3 ticks, ring=1 again.
- Snooze twice, then press a third time -> snooze_cnt_o stays 2 and ring stays 1; stop_pb -> IDLE.
- Ringing, stop_pb and snooze_pb rise in the same cycle -> state_o=0, snooze_cnt_o unchanged. Holding time at the match afterwards -> no re-ring.
- alarm_en=0 at the match -> ring stays 0. alarm_en dropped during SNOOZE -> IDLE, no later ring.
- Assert reset mid-RINGING, with sec_tick coincident with a button edge -> all outputs 0 immediately. After reset release, a fresh match rings again.
